// File: rtl/flit_axis_deserializer.sv
// Credit-based flit receiver: buffers flits, returns credits, packs SERIALIZATION_FACTOR flits per AXIS beat.
// Latency: send -> pop +1, credit +2, tvalid +1 after the completing pop. Backpressure: tready=0 stalls pops, so credits stop.
// Optional sticky overflow port with FLIT_DESER_OVERFLOW_CHECK_EN.

// Generic synchronous FIFO with first-word-fall-through read port.
// Latency: write visible on rd_dat the next cycle. Backpressure: writes while full are dropped unless a pop frees a slot.
// Write and pop in the same cycle are both honoured.
module flit_deser_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Extra pointer MSB separates full from empty when the low bits match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok  = rd_en && !empty;
  assign wr_ok  = wr_en && (!full || rd_ok);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// NoC egress endpoint: flit FIFO feeding a slice assembler and a registered AXIS master.
// Latency: send at t -> pop t+1 -> credit t+2; beat valid the cycle after its completing pop.
// Backpressure: while a beat waits on tready no flits are popped and no credits return.
module flit_axis_deserializer #(
  parameter int TDEST_WIDTH          = 6,
  parameter int TDATA_WIDTH          = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_in,
  input  logic [TDEST_WIDTH-1:0]        dest_in,
  input  logic                          is_tail_in,
  input  logic                          send_in,
  output logic                          credit_out,
  output logic                          axis_tvalid,
  input  logic                          axis_tready,
  output logic [TDATA_WIDTH-1:0]        axis_tdata,
  output logic                          axis_tlast,
  output logic [TDEST_WIDTH-1:0]        axis_tdest
`ifdef FLIT_DESER_OVERFLOW_CHECK_EN
  ,
  output logic                          overflow
`endif
);
  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int SLICE_W    = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(SERIALIZATION_FACTOR - 1);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0]  data;
    logic [TDEST_WIDTH-1:0] dest;
    logic                   tail;
  } flit_t;

  typedef enum logic {
    S_ASSEMBLE = 1'b0,
    S_OUTPUT   = 1'b1
  } state_t;

  state_t                 state;
  flit_t                  wr_flit;
  flit_t                  head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;
  logic                   completing;
  logic [SLICE_W-1:0]     slice_idx;
  logic [TDATA_WIDTH-1:0] asm_reg;
  logic [TDATA_WIDTH-1:0] asm_next;

  assign wr_flit = '{data: data_in, dest: dest_in, tail: is_tail_in};

  flit_deser_fifo #(
    .WIDTH ($bits(flit_t)),
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (send_in),
    .wr_dat (wr_flit),
    .rd_en  (pop),
    .rd_dat (head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // A held beat only releases the FIFO in the cycle it is accepted.
  assign pop        = !fifo_empty && ((state == S_ASSEMBLE) || axis_tready);
  assign completing = pop && ((slice_idx == LAST_SLICE) || head.tail);

  always_comb begin
    asm_next = asm_reg;
    if (pop) asm_next[slice_idx*FLIT_WIDTH +: FLIT_WIDTH] = head.data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_ASSEMBLE;
      slice_idx   <= '0;
      asm_reg     <= '0;
      credit_out  <= 1'b0;
      axis_tvalid <= 1'b0;
      axis_tdata  <= '0;
      axis_tlast  <= 1'b0;
      axis_tdest  <= '0;
    end else begin
      credit_out <= pop;
      if ((state == S_OUTPUT) && axis_tready) begin
        axis_tvalid <= 1'b0;
        state       <= S_ASSEMBLE;
      end
      // Assembly register is cleared on every completion, so an early tail leaves upper slices zero.
      if (pop) begin
        if (completing) begin
          axis_tdata  <= asm_next;
          axis_tlast  <= head.tail;
          axis_tdest  <= head.dest;
          axis_tvalid <= 1'b1;
          state       <= S_OUTPUT;
          asm_reg     <= '0;
          slice_idx   <= '0;
        end else begin
          asm_reg     <= asm_next;
          slice_idx   <= slice_idx + 1'b1;
        end
      end
    end
  end

`ifdef FLIT_DESER_OVERFLOW_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (send_in && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end
`endif
endmodule
